// File: rtl/reordenar_pkg.sv
// Shared constants and types for the streaming byte reorder block.
package reordenar_pkg;

  localparam logic [1:0] MODO_PASS = 2'b00;
  localparam logic [1:0] MODO_BREV = 2'b01;
  localparam logic [1:0] MODO_PSWP = 2'b10;
  localparam logic [1:0] MODO_BITR = 2'b11;

  localparam int unsigned NBYTES_MAX = 64;

  // Occupancy of the OUT/SKID pair
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } estado_t;

endpackage

// File: rtl/reordenar_bytes_comb.sv
// Combinational word permutation: pass, byte reverse, byte-pair swap, bit reverse.
module reordenar_bytes_comb
  import reordenar_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic [8*NBYTES-1:0] entrada,
  input  logic [1:0]          modo,
  output logic [8*NBYTES-1:0] permutado
);

  localparam int unsigned W = 8 * NBYTES;

  logic [W-1:0] brev;
  logic [W-1:0] pswp;
  logic [W-1:0] bitr;

  for (genvar k = 0; k < int'(NBYTES); k++) begin : g_byte
    assign brev[8*k +: 8] = entrada[8*(int'(NBYTES)-1-k) +: 8];

    // An odd top byte has no partner and passes through
    if ((k % 2 == 0) && (k + 1 < int'(NBYTES))) begin : g_sw_lo
      assign pswp[8*k +: 8] = entrada[8*(k+1) +: 8];
    end else if (k % 2 == 1) begin : g_sw_hi
      assign pswp[8*k +: 8] = entrada[8*(k-1) +: 8];
    end else begin : g_sw_keep
      assign pswp[8*k +: 8] = entrada[8*k +: 8];
    end
  end

  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    assign bitr[i] = entrada[int'(W)-1-i];
  end

  always_comb begin
    permutado = entrada;
    case (modo)
      MODO_PASS: permutado = entrada;
      MODO_BREV: permutado = brev;
      MODO_PSWP: permutado = pswp;
      MODO_BITR: permutado = bitr;
      default:   permutado = entrada;
    endcase
  end

endmodule

// File: rtl/reordenar_bytes_stream.sv
// Valid/ready byte reorder stage: permute on acceptance, 2-entry OUT/SKID buffer, beat counter.
module reordenar_bytes_stream
  import reordenar_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8*NBYTES-1:0] entrada,
  input  logic [1:0]          modo,
  input  logic                entrada_valid,
  output logic                entrada_ready,
  output logic [8*NBYTES-1:0] saida,
  output logic                saida_valid,
  input  logic                saida_ready,
  output logic [CNT_W-1:0]    contador
);

  localparam int unsigned W = 8 * NBYTES;

  estado_t      estado;
  logic [W-1:0] skid;
  logic [W-1:0] permutado;
  logic         acc;
  logic         tk;

  reordenar_bytes_comb #(
    .NBYTES (NBYTES)
  ) u_comb (
    .entrada   (entrada),
    .modo      (modo),
    .permutado (permutado)
  );

  assign acc = entrada_valid & entrada_ready;
  assign tk  = saida_valid & saida_ready;

  // entrada_ready tracks "SKID will be free next cycle"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado        <= ST_EMPTY;
      saida         <= '0;
      saida_valid   <= 1'b0;
      skid          <= '0;
      entrada_ready <= 1'b0;
      contador      <= '0;
    end else begin
      if (tk) begin
        contador <= contador + CNT_W'(1);
      end
      case (estado)
        ST_EMPTY: begin
          entrada_ready <= 1'b1;
          if (acc) begin
            saida       <= permutado;
            saida_valid <= 1'b1;
            estado      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && !tk) begin
            skid          <= permutado;
            entrada_ready <= 1'b0;
            estado        <= ST_TWO;
          end else if (acc) begin
            saida <= permutado;
          end else if (tk) begin
            saida_valid <= 1'b0;
            estado      <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (tk) begin
            saida         <= skid;
            entrada_ready <= 1'b1;
            estado        <= ST_ONE;
          end
        end
        default: begin
          saida_valid   <= 1'b0;
          entrada_ready <= 1'b0;
          estado        <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reordenar_bytes_stream.sv
// Bench for reordenar_bytes_stream: vector table, directed corners, random traffic vs queue model.
module tb_reordenar_bytes_stream;
  import reordenar_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] entrada, saida;
  logic [1:0]  modo;
  logic        entrada_valid, entrada_ready, saida_valid, saida_ready;
  logic [15:0] contador;

  logic [23:0] e3, s3;
  logic [1:0]  m3;
  logic        ev3, er3, sv3, sr3;
  logic [3:0]  c3;

  reordenar_bytes_stream #(.NBYTES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .entrada(entrada), .modo(modo),
    .entrada_valid(entrada_valid), .entrada_ready(entrada_ready),
    .saida(saida), .saida_valid(saida_valid), .saida_ready(saida_ready),
    .contador(contador)
  );

  reordenar_bytes_stream #(.NBYTES(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .entrada(e3), .modo(m3),
    .entrada_valid(ev3), .entrada_ready(er3),
    .saida(s3), .saida_valid(sv3), .saida_ready(sr3),
    .contador(c3)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference permutation from the mode definitions, for any byte count
  function automatic logic [511:0] perm_ref(input logic [511:0] x, input int nb, input logic [1:0] m);
    logic [511:0] r;
    int p;
    r = '0;
    case (m)
      MODO_PASS: for (int k = 0; k < nb; k++) r[8*k +: 8] = x[8*k +: 8];
      MODO_BREV: for (int k = 0; k < nb; k++) r[8*k +: 8] = x[8*(nb-1-k) +: 8];
      MODO_PSWP: for (int k = 0; k < nb; k++) begin
        p = k ^ 1;
        if (p >= nb) p = k;
        r[8*k +: 8] = x[8*p +: 8];
      end
      default:   for (int i = 0; i < 8*nb; i++) r[i] = x[8*nb-1-i];
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref32(input logic [31:0] x, input logic [1:0] m);
    logic [511:0] t;
    t = perm_ref(512'(x), 4, m);
    return t[31:0];
  endfunction

  function automatic logic [23:0] ref24(input logic [23:0] x, input logic [1:0] m);
    logic [511:0] t;
    t = perm_ref(512'(x), 3, m);
    return t[23:0];
  endfunction

  // Scoreboard: sampled on the falling edge, handshakes resolve on the next rising edge
  logic [31:0] q[$];
  int unsigned exp_cnt = 0;
  int n_out = 0;
  int cyc = 0;
  int first_out_cyc = -1;
  int last_out_cyc = -1;
  logic prev_stall = 1'b0;
  logic [31:0] prev_saida = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      chk("valid_vs_occupancy", 64'(saida_valid), 64'(q.size() != 0));
      if (q.size() >= 2) chk("ready_when_full", 64'(entrada_ready), 64'(0));
      chk("contador_model", 64'(contador), 64'(exp_cnt[15:0]));
      if (prev_stall) chk("stall_hold", 64'({saida_valid, saida}), 64'({1'b1, prev_saida}));
      if (saida_valid && saida_ready) begin
        if (q.size() == 0) begin
          chk("output_without_beat", 64'(q.size()), 64'(1));
        end else begin
          chk("saida_order", 64'(saida), 64'(q[0]));
          void'(q.pop_front());
          exp_cnt++;
          n_out++;
          if (first_out_cyc < 0) first_out_cyc = cyc;
          last_out_cyc = cyc;
        end
      end
      if (entrada_valid && entrada_ready) q.push_back(ref32(entrada, modo));
      prev_stall = saida_valid && !saida_ready;
      prev_saida = saida;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] din;
    logic [1:0]  m;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    vec_t tab[5];
    logic [31:0] a, b, c, d;
    logic [1:0] ma, mb, mc, md;
    logic [23:0] x3;
    logic [1:0] mx3;
    bit will_acc;
    int base, waited;

    tab[0] = '{32'h11223344, MODO_BREV, 32'h44332211};
    tab[1] = '{32'h80C00001, MODO_PASS, 32'h80C00001};
    tab[2] = '{32'h80C00001, MODO_BREV, 32'h0100C080};
    tab[3] = '{32'h80C00001, MODO_PSWP, 32'hC0800100};
    tab[4] = '{32'h80C00001, MODO_BITR, 32'h80000301};

    rst = 1'b1;
    entrada = '0; modo = '0; entrada_valid = 1'b0; saida_ready = 1'b0;
    e3 = '0; m3 = '0; ev3 = 1'b0; sr3 = 1'b0;
    tick; tick;
    chk("reset_saida", 64'(saida), 64'(0));
    chk("reset_valid", 64'(saida_valid), 64'(0));
    chk("reset_ready", 64'(entrada_ready), 64'(0));
    chk("reset_contador", 64'(contador), 64'(0));
    rst = 1'b0;
    chk("ready_before_edge", 64'(entrada_ready), 64'(0));
    tick;
    chk("ready_after_release", 64'(entrada_ready), 64'(1));

    // Mode vectors, one beat at a time
    for (int i = 0; i < 5; i++) begin
      entrada = tab[i].din; modo = tab[i].m; entrada_valid = 1'b1; saida_ready = 1'b1;
      tick;
      entrada_valid = 1'b0;
      modo = ~modo;
      chk("vec_valid", 64'(saida_valid), 64'(1));
      chk("vec_saida", 64'(saida), 64'(tab[i].exp));
      tick;
      chk("vec_contador", 64'(contador), 64'(i + 1));
    end

    // Backpressure: A, B fill both entries, C is held off
    a = 32'hA1A2A3A4; ma = MODO_BREV;
    b = 32'hB1B2B3B4; mb = MODO_PSWP;
    c = 32'hC1C2C3C4; mc = MODO_BITR;
    saida_ready = 1'b0;
    entrada = a; modo = ma; entrada_valid = 1'b1;
    tick;
    chk("bp_saida_a", 64'(saida), 64'(ref32(a, ma)));
    chk("bp_ready_one", 64'(entrada_ready), 64'(1));
    entrada = b; modo = mb;
    tick;
    chk("bp_ready_two", 64'(entrada_ready), 64'(0));
    entrada = c; modo = mc;
    tick; tick;
    chk("bp_stall_saida", 64'(saida), 64'(ref32(a, ma)));
    chk("bp_stall_ready", 64'(entrada_ready), 64'(0));
    saida_ready = 1'b1;
    tick;
    chk("bp_saida_b", 64'(saida), 64'(ref32(b, mb)));
    tick;
    entrada_valid = 1'b0;
    chk("bp_saida_c", 64'(saida), 64'(ref32(c, mc)));
    tick;
    chk("bp_drained", 64'(saida_valid), 64'(0));

    // Throughput from a clean counter
    rst = 1'b1; tick; rst = 1'b0; tick;
    base = n_out; first_out_cyc = -1;
    saida_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      entrada = $urandom; modo = 2'($urandom); entrada_valid = 1'b1;
      chk("tput_ready", 64'(entrada_ready), 64'(1));
      tick;
    end
    entrada_valid = 1'b0;
    tick;
    chk("tput_beats", 64'(n_out - base), 64'(100));
    chk("tput_span", 64'(last_out_cyc - first_out_cyc + 1), 64'(100));
    chk("tput_contador", 64'(contador), 64'(100));

    // Random traffic with producer hold rule and random backpressure
    will_acc = 1'b0;
    for (int c2 = 0; c2 < 600; c2++) begin
      if (!entrada_valid || will_acc) begin
        entrada_valid = ($urandom_range(0, 3) != 0);
        entrada = $urandom; modo = 2'($urandom);
      end
      saida_ready = ($urandom_range(0, 3) != 0);
      will_acc = entrada_valid && entrada_ready;
      tick;
    end
    entrada_valid = 1'b0; saida_ready = 1'b1;
    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      tick;
      waited++;
    end
    chk("random_drain", 64'(q.size()), 64'(0));

    // Async reset while both entries are full
    saida_ready = 1'b0;
    entrada = 32'h01020304; modo = MODO_BREV; entrada_valid = 1'b1;
    tick;
    entrada = 32'h05060708;
    tick;
    entrada_valid = 1'b0;
    chk("two_ready", 64'(entrada_ready), 64'(0));
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 64'(saida_valid), 64'(0));
    chk("async_contador", 64'(contador), 64'(0));
    chk("async_saida", 64'(saida), 64'(0));
    chk("async_ready", 64'(entrada_ready), 64'(0));
    tick;
    rst = 1'b0;
    tick;
    d = 32'hDEADBEEF; md = MODO_BITR;
    entrada = d; modo = md; entrada_valid = 1'b1; saida_ready = 1'b1;
    tick;
    entrada_valid = 1'b0;
    chk("post_reset_first", 64'(saida), 64'(ref32(d, md)));
    tick;
    chk("post_reset_contador", 64'(contador), 64'(1));

    // NBYTES=3 / CNT_W=4 instance
    sr3 = 1'b1;
    e3 = 24'hAABBCC; m3 = MODO_PSWP; ev3 = 1'b1;
    tick;
    chk("n3_pswp", 64'(s3), 64'(24'hAACCBB));
    chk("n3_valid", 64'(sv3), 64'(1));
    for (int i = 1; i < 17; i++) begin
      x3 = 24'($urandom); mx3 = 2'($urandom);
      e3 = x3; m3 = mx3;
      tick;
      chk("n3_beat", 64'(s3), 64'(ref24(x3, mx3)));
    end
    ev3 = 1'b0;
    tick;
    chk("n3_contador_wrap", 64'(c3), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
